block_manager: RTL
==================

BLOCK_MANAGER -- requirements
Module: block_manager

Interface
REQ-001 Parameter POINTS_PER_BLOCK, default 10, score increment per newly destroyed block.
REQ-002 Parameter CLEAR_HOLD_FRAMES, default 60, frames level_clear is held before reload.
REQ-003 pclk  in  1  pixel clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vblnk_in  in  1  vertical blank from timing chain; rising edge = frame boundary.
REQ-006 hit_req_a / hit_req_b  in  1 each  hit request from requester A (ball collision) / B (projectile); held until acked.
REQ-007 hit_idx_a / hit_idx_b  in  4 each  block index 0..15, bit n of mask; stable while req high.
REQ-008 hit_ack_a / hit_ack_b  out  1 each  one-cycle acknowledge.
REQ-009 new_level  in  1  one-cycle pulse; restart level.
REQ-010 blocks_out  out  16  committed destroyed-block mask, 1 = destroyed; feeds board renderer.
REQ-011 blocks_left  out  5  count of zero bits in blocks_out, 0..16.
REQ-012 score  out  16  accumulated score.
REQ-013 level_clear  out  1  high while in CLEARED state.

Function
REQ-014 Internal pending mask accumulates accepted hits; blocks_out SHALL update only on the pclk after a vblnk_in rising edge (blocks_out <= pending), never mid-frame.
REQ-015 Arbiter: at most one grant per cycle; when both request, round-robin, starting with A after reset; a lone requester is granted immediately.
REQ-016 Granted request: pending[idx] set, hit_ack asserted on the next cycle for exactly one cycle; the granted requester is not regranted in the ack cycle.
REQ-017 Hit on an index already set in pending: acked normally, pending and score unchanged.
REQ-018 Both requesters same index same cycle: winner scores; loser acked later as duplicate per REQ-017.
REQ-019 Score adds POINTS_PER_BLOCK in the grant cycle for each newly set bit; saturates at 16'hFFFF.
REQ-020 blocks_left recomputed from blocks_out, registered, valid one cycle after blocks_out changes.
REQ-021 FSM states PLAY, CLEARED, RELOAD; reset -> PLAY.
REQ-022 PLAY -> CLEARED when committed blocks_out == 16'hFFFF.
REQ-023 CLEARED: requests not acked (no grants); frame counter increments per vblnk_in rising edge; -> RELOAD when counter == CLEAR_HOLD_FRAMES.
REQ-024 RELOAD: at next vblnk_in rising edge pending and blocks_out cleared to 0, frame counter 0, -> PLAY; score retained.
REQ-025 new_level in any state: pending cleared immediately, -> RELOAD; score retained; a grant in the same cycle is discarded and not acked.
REQ-026 Requests seen in RELOAD are held off until PLAY.

Reset
REQ-027 reset SHALL force: state PLAY, blocks_out 0, pending 0, blocks_left 16, score 0, level_clear 0, hit_ack_a/b 0, frame counter 0, round-robin pointer to A.
REQ-028 reset mid-transaction: outstanding requests unacked; requester retries after reset.

Configuration
REQ-029 Macro BLOCK_MGR_SCORE_EN defined: score logic per REQ-019 present.
REQ-030 Macro undefined: score tied to 16'h0000, no score adder or register synthesized; all other behaviour identical.

Verification
REQ-031 Reset, A hits idx 3 -> ack_a one cycle later; blocks_out stays 0 until next vblnk rise, then 16'h0008; blocks_left 15; score 10.
REQ-032 A idx 1 and B idx 2 same cycle -> ack_a at t+1, ack_b at t+2; after vblnk blocks_out 16'h0006, score 20.
REQ-033 A and B both idx 5 -> both acked, blocks_out 16'h0020, score 10 only.
REQ-034 Hit all 16 -> after vblnk level_clear 1; new requests unacked; after 60 vblnk rises plus one more, blocks_out 0, level_clear 0, score 160.
REQ-035 new_level pulse with pending 16'h00F0 -> at next vblnk blocks_out 0; score unchanged.
REQ-036 Without BLOCK_MGR_SCORE_EN, repeat REQ-031 -> score 0, mask and ack behaviour unchanged.

Source files
------------

// File: rtl/block_manager.sv
// Destroyed-block bookkeeping for the breakout board: two-requester hit arbitration,
// frame-synchronous mask commit, level FSM. Define BLOCK_MGR_SCORE_EN to build the score counter.
module block_manager #(
   parameter int POINTS_PER_BLOCK  = 10,
   parameter int CLEAR_HOLD_FRAMES = 60
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        vblnk_in,
   input  logic        hit_req_a,
   input  logic        hit_req_b,
   input  logic [3:0]  hit_idx_a,
   input  logic [3:0]  hit_idx_b,
   output logic        hit_ack_a,
   output logic        hit_ack_b,
   input  logic        new_level,
   output logic [15:0] blocks_out,
   output logic [4:0]  blocks_left,
   output logic [15:0] score,
   output logic        level_clear
);
   localparam int CNT_W = $clog2(CLEAR_HOLD_FRAMES + 2);

   typedef enum logic [1:0] {PLAY, CLEARED, RELOAD} state_t;

   state_t           state_reg, state_next;
   logic             vblnk_d_reg;
   logic             vblnk_rise;
   logic [15:0]      pending_reg;
   logic [15:0]      blocks_reg;
   logic [4:0]       left_reg, left_next;
   logic [CNT_W-1:0] frame_cnt_reg;
   logic             ack_a_reg, ack_b_reg;
   logic             prio_b_reg;
   logic             elig_a, elig_b;
   logic             grant_a, grant_b, grant_any;
   logic [3:0]       grant_idx;

   assign vblnk_rise = vblnk_in & ~vblnk_d_reg;

   // A requester is masked during its own ack cycle so a still-high request is not regranted.
   always_comb begin
      elig_a  = hit_req_a & ~ack_a_reg;
      elig_b  = hit_req_b & ~ack_b_reg;
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_reg == PLAY && !new_level) begin
         if (elig_a && elig_b) begin
            grant_a = ~prio_b_reg;
            grant_b = prio_b_reg;
         end else begin
            grant_a = elig_a;
            grant_b = elig_b;
         end
      end
   end

   assign grant_any = grant_a | grant_b;
   assign grant_idx = grant_a ? hit_idx_a : hit_idx_b;

   always_comb begin
      state_next = state_reg;
      if (new_level) begin
         state_next = RELOAD;
      end else begin
         case (state_reg)
            PLAY:    if (blocks_reg == 16'hFFFF) state_next = CLEARED;
            CLEARED: if (frame_cnt_reg == CNT_W'(CLEAR_HOLD_FRAMES)) state_next = RELOAD;
            RELOAD:  if (vblnk_rise) state_next = PLAY;
            default: state_next = PLAY;
         endcase
      end
   end

   always_comb begin
      left_next = 5'd0;
      for (int i = 0; i < 16; i++) begin
         left_next = left_next + {4'd0, ~blocks_reg[i]};
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_reg     <= PLAY;
         vblnk_d_reg   <= 1'b0;
         pending_reg   <= '0;
         blocks_reg    <= '0;
         left_reg      <= 5'd16;
         frame_cnt_reg <= '0;
         ack_a_reg     <= 1'b0;
         ack_b_reg     <= 1'b0;
         prio_b_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         vblnk_d_reg <= vblnk_in;
         ack_a_reg   <= grant_a;
         ack_b_reg   <= grant_b;
         left_reg    <= left_next;
         // Pointer only moves on contention; lone grants leave the turn order alone.
         if (elig_a && elig_b && grant_any) prio_b_reg <= grant_a;

         if (new_level || (vblnk_rise && state_reg == RELOAD)) pending_reg <= '0;
         else if (grant_any) pending_reg[grant_idx] <= 1'b1;

         if (vblnk_rise) begin
            if (state_reg == RELOAD) begin
               blocks_reg    <= '0;
               frame_cnt_reg <= '0;
            end else begin
               blocks_reg <= pending_reg;
               if (state_reg == CLEARED) frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
         end
      end
   end

`ifdef BLOCK_MGR_SCORE_EN
   logic        new_bit;
   logic [15:0] score_reg;
   logic [16:0] score_sum;

   assign new_bit   = grant_any & ~pending_reg[grant_idx];
   assign score_sum = {1'b0, score_reg} + 17'(POINTS_PER_BLOCK);

   always_ff @(posedge pclk) begin
      if (reset) begin
         score_reg <= '0;
      end else if (new_bit) begin
         score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
   end

   assign score = score_reg;
`else
   assign score = 16'h0000;
`endif

   assign hit_ack_a   = ack_a_reg;
   assign hit_ack_b   = ack_b_reg;
   assign blocks_out  = blocks_reg;
   assign blocks_left = left_reg;
   assign level_clear = (state_reg == CLEARED);

endmodule
